// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - multi-cycle load/store sequencer with sub-word read-modify-write
// Optional: define UNSIGNED_LOAD_EN to add LBU/LHU zero-extending loads.
module mem_access_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [5:0]            OpCode,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  Stall,
  output logic                  Done,
  output logic                  AddrErr,
  output logic                  BusErr,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [31:0]           MemWData,
  output logic                  MemWE,
  output logic                  MemRE,
  input  logic [31:0]           MemRData,
  input  logic                  MemReady
);
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_d;

  logic [5:0]       op_q;
  logic [1:0]       lane_q;
  logic [15:0]      wdata_q;
  logic [CNT_W-1:0] wdog;
  logic             supported, misaligned, accept, timeout, load_done, rmw_go, bus_fail;
  logic [4:0]       bsh, hsh;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      load_val, merge_val;

  always_comb begin
    supported  = 1'b0;
    misaligned = 1'b0;
    case (OpCode)
      OP_LW, OP_SW: begin supported = 1'b1; misaligned = |Addr[1:0]; end
      OP_LH, OP_SH: begin supported = 1'b1; misaligned = Addr[0];    end
      OP_LB, OP_SB: supported = 1'b1;
`ifdef UNSIGNED_LOAD_EN
      OP_LHU:       begin supported = 1'b1; misaligned = Addr[0];    end
      OP_LBU:       supported = 1'b1;
`endif
      default: ;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores, both from the word just read
  always_comb begin
    bsh    = {lane_q, 3'b000};
    hsh    = {lane_q[1], 4'b0000};
    byte_v = 8'(MemRData >> bsh);
    half_v = 16'(MemRData >> hsh);
    case (op_q)
      OP_LH:   load_val = {{16{half_v[15]}}, half_v};
      OP_LB:   load_val = {{24{byte_v[7]}}, byte_v};
`ifdef UNSIGNED_LOAD_EN
      OP_LHU:  load_val = {16'h0000, half_v};
      OP_LBU:  load_val = {24'h000000, byte_v};
`endif
      default: load_val = MemRData;
    endcase
    if (op_q == OP_SB)
      merge_val = (MemRData & ~(32'h0000_00FF << bsh)) | ({24'h0, wdata_q[7:0]} << bsh);
    else
      merge_val = (MemRData & ~(32'h0000_FFFF << hsh)) | ({16'h0, wdata_q} << hsh);
  end

  always_comb begin
    state_d   = state;
    Stall     = 1'b0;
    Done      = 1'b0;
    MemRE     = 1'b0;
    MemWE     = 1'b0;
    accept    = 1'b0;
    load_done = 1'b0;
    rmw_go    = 1'b0;
    bus_fail  = 1'b0;
    timeout   = (wdog == CNT_W'(TIMEOUT - 1));
    case (state)
      IDLE: begin
        if (Start && supported) begin
          Stall  = 1'b1;
          accept = 1'b1;
          if (misaligned)          state_d = DONE;
          else if (OpCode == OP_SW) state_d = WRITE;
          else                     state_d = READ;
        end
      end
      READ: begin
        Stall = 1'b1;
        MemRE = 1'b1;
        if (MemReady) begin
          if (op_q == OP_SB || op_q == OP_SH) begin
            rmw_go  = 1'b1;
            state_d = WRITE;
          end else begin
            load_done = 1'b1;
            state_d   = DONE;
          end
        end else if (timeout) begin
          bus_fail = 1'b1;
          state_d  = DONE;
        end
      end
      WRITE: begin
        Stall = 1'b1;
        MemWE = 1'b1;
        if (MemReady) state_d = DONE;
        else if (timeout) begin
          bus_fail = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_d;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      op_q     <= '0;
      lane_q   <= '0;
      wdata_q  <= '0;
      wdog     <= '0;
      ReadData <= '0;
      AddrErr  <= 1'b0;
      BusErr   <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
    end else begin
      if (accept) begin
        op_q    <= OpCode;
        lane_q  <= Addr[1:0];
        wdata_q <= WriteData[15:0];
        MemAddr <= {Addr[ADDR_WIDTH-1:2], 2'b00};
        AddrErr <= misaligned;
        BusErr  <= 1'b0;
        if (OpCode == OP_SW) MemWData <= WriteData;
      end
      if (rmw_go)    MemWData <= merge_val;
      if (load_done) ReadData <= load_val;
      if (bus_fail)  BusErr   <= 1'b1;
      // Watchdog restarts for every memory phase, including the write half of an RMW
      if (state_d != state && (state_d == READ || state_d == WRITE))
        wdog <= '0;
      else if ((state == READ || state == WRITE) && !MemReady)
        wdog <= wdog + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - scoreboard bench for mem_access_sequencer
// Define UNSIGNED_LOAD_EN for both bench and RTL to exercise LBU/LHU.
module tb_mem_access_sequencer;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LBU = 6'b100100;
`ifdef UNSIGNED_LOAD_EN
  localparam logic [5:0] OP_LHU = 6'b100101;
`endif

  logic        Clk, Rst, Start;
  logic [5:0]  OpCode;
  logic [31:0] Addr, WriteData, ReadData, MemAddr, MemWData, MemRData;
  logic        Stall, Done, AddrErr, BusErr, MemWE, MemRE, MemReady;

  mem_access_sequencer #(.ADDR_WIDTH(32), .TIMEOUT(16), .CNT_W(5)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .OpCode(OpCode), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .Done(Done),
    .AddrErr(AddrErr), .BusErr(BusErr), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemWE(MemWE), .MemRE(MemRE), .MemRData(MemRData), .MemReady(MemReady)
  );

  typedef struct {
    logic [31:0] rd;
    logic        ae;
    logic        be;
    int          lat;
    int          re;
    int          we;
    logic [31:0] wd;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem[4];
  int          compared = 0, mismatched = 0;
  int          cyc = 0, done_cnt = 0, wait_left = 0;
  logic        stuck = 1'b0;

  assign MemRData = mem[MemAddr[3:2]];
  assign MemReady = !stuck && (wait_left == 0);

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, want);
    end
  endtask

  // Word memory: writes commit on a ready write phase; wait_left delays ready by that many busy edges
  initial begin
    forever begin
      @(posedge Clk);
      cyc = cyc + 1;
      if (MemWE && MemReady) mem[MemAddr[3:2]] <= MemWData;
      if ((MemRE || MemWE) && wait_left > 0) wait_left <= wait_left - 1;
    end
  end

  initial begin : monitor
    int   re_c, we_c;
    exp_t e;
    re_c = 0;
    we_c = 0;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        re_c = 0;
        we_c = 0;
      end else begin
        if (MemRE) re_c++;
        if (MemWE) we_c++;
        if (MemRE && MemWE) check("re_we_overlap", 32'd1, 32'd0);
        if (MemWE && MemReady) check("mem_wdata", MemWData, q.size() > 0 ? q[0].wd : 32'hx);
        if (Done) begin
          if (q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
          else begin
            e = q.pop_front();
            check("read_data", ReadData, e.rd);
            check("addr_err", {31'd0, AddrErr}, {31'd0, e.ae});
            check("bus_err", {31'd0, BusErr}, {31'd0, e.be});
            check("latency", cyc - e.t, e.lat);
            check("re_cycles", re_c, e.re);
            check("we_cycles", we_c, e.we);
            check("stall_in_done", {31'd0, Stall}, 32'd0);
          end
          re_c = 0;
          we_c = 0;
          done_cnt++;
        end
      end
    end
  end

  task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic ae, input logic be,
                     input int lat, input int re, input int we, input logic [31:0] wdx);
    exp_t e;
    int   n;
    bit   got;
    @(posedge Clk);
    #1;
    e.rd = rd; e.ae = ae; e.be = be; e.lat = lat; e.re = re; e.we = we; e.wd = wdx; e.t = cyc;
    q.push_back(e);
    n = done_cnt;
    Start = 1'b1; OpCode = op; Addr = a; WriteData = wd;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge Clk);
      #1;
      if (done_cnt != n) got = 1'b1;
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; OpCode = '0; Addr = '0; WriteData = '0;
    mem[0] = 32'h8899_AABB; mem[1] = 32'h1122_3344; mem[2] = '0; mem[3] = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_memre_we", {30'd0, MemRE, MemWE}, 32'd0);
    check("rst_readdata", ReadData, 32'd0);
    check("rst_memaddr", MemAddr, 32'd0);
    Rst = 1'b1;

    run(OP_LB, 32'h2, 32'h0,         32'hFFFF_FF99, 0, 0, 2, 1, 0, 32'hx);
    run(OP_SB, 32'h1, 32'h1234_5677, 32'hFFFF_FF99, 0, 0, 3, 1, 1, 32'h8899_77BB);
    check("mem0_after_sb", mem[0], 32'h8899_77BB);
    mem[0] = 32'h1122_3344;
    run(OP_SH, 32'h2, 32'h0000_CAFE, 32'hFFFF_FF99, 0, 0, 3, 1, 1, 32'hCAFE_3344);
    run(OP_LH, 32'h2, 32'h0,         32'hFFFF_CAFE, 0, 0, 2, 1, 0, 32'hx);
    run(OP_LW, 32'h6, 32'h0,         32'hFFFF_CAFE, 1, 0, 1, 0, 0, 32'hx);
    wait_left = 3;
    run(OP_SW, 32'h4, 32'hDEAD_BEEF, 32'hFFFF_CAFE, 0, 0, 5, 0, 4, 32'hDEAD_BEEF);
    run(OP_LW, 32'h4, 32'h0,         32'hDEAD_BEEF, 0, 0, 2, 1, 0, 32'hx);
    stuck = 1'b1;
    run(OP_LW, 32'h0, 32'h0,         32'hDEAD_BEEF, 0, 1, 17, 16, 0, 32'hx);
    stuck = 1'b0;
    run(OP_LH, 32'h1, 32'h0,         32'hDEAD_BEEF, 1, 0, 1, 0, 0, 32'hx);

    // Reset mid-write of an SB: the pending RMW must never reach memory
    @(posedge Clk);
    #1;
    Start = 1'b1; OpCode = OP_SB; Addr = 32'h0; WriteData = 32'h55;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    @(posedge Clk);
    #1;
    stuck = 1'b1;
    #1;
    check("we_before_reset", {31'd0, MemWE}, 32'd1);
    Rst = 1'b0;
    #1;
    check("rst_mid_we", {31'd0, MemWE}, 32'd0);
    check("rst_mid_stall", {31'd0, Stall}, 32'd0);
    check("rst_mid_readdata", ReadData, 32'd0);
    check("rst_mid_memaddr", MemAddr, 32'd0);
    check("rst_mid_memwdata", MemWData, 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    check("rst_mid_mem0", mem[0], 32'hCAFE_3344);
    Rst = 1'b1;
    stuck = 1'b0;

    mem[0] = 32'h8000_0000;
    run(OP_LB, 32'h3, 32'h0, 32'hFFFF_FF80, 0, 0, 2, 1, 0, 32'hx);
`ifdef UNSIGNED_LOAD_EN
    run(OP_LBU, 32'h3, 32'h0, 32'h0000_0080, 0, 0, 2, 1, 0, 32'hx);
    run(OP_LHU, 32'h2, 32'h0, 32'h0000_8000, 0, 0, 2, 1, 0, 32'hx);
    run(OP_LHU, 32'h1, 32'h0, 32'h0000_8000, 1, 0, 1, 0, 0, 32'hx);
`else
    begin
      int n;
      @(posedge Clk);
      #1;
      n = done_cnt;
      Start = 1'b1; OpCode = OP_LBU; Addr = 32'h3;
      #1;
      check("lbu_stall", {31'd0, Stall}, 32'd0);
      @(posedge Clk);
      #1;
      Start = 1'b0;
      repeat (8) @(negedge Clk);
      #1;
      check("lbu_no_done", done_cnt, n);
    end
`endif

    repeat (4) @(posedge Clk);
    check("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Multi-cycle load/store sequencer between the datapath and a word-wide data memory with a ready handshake.
- Accepts one memory instruction at a time: LW, LH, LB, SW, SH, SB.
- Performs read-modify-write for sub-word stores, and extracts and sign-extends sub-word loads.
- Holds Stall to freeze the datapath until the access completes, making sub-word memory access read/write safe.

Parameters:
ADDR_WIDTH, 32, byte address width.
TIMEOUT, 16, maximum cycles to wait for MemReady per memory phase before a bus error.
CNT_W, 5, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
Clk  input  1  system clock, rising edge.
Rst  input  1  asynchronous active-low reset.
Start  input  1  request pulse from datapath (MemRead|MemWrite decoded).
OpCode  input  6  instruction opcode: 100011 LW, 100001 LH, 100000 LB, 101011 SW, 101001 SH, 101000 SB.
Addr  input  ADDR_WIDTH  byte address (ALU result).
WriteData  input  32  store data (rt).
ReadData  output  32  load result, extended as required.
Stall  output  1  datapath hold.
Done  output  1  one-cycle completion pulse.
AddrErr  output  1  misaligned access flag, valid with Done.
BusErr  output  1  memory timeout flag, valid with Done.
MemAddr  output  ADDR_WIDTH  word-aligned memory address.
MemWData  output  32  memory write data.
MemWE  output  1  memory write enable.
MemRE  output  1  memory read enable.
MemRData  input  32  memory read data.
MemReady  input  1  memory phase complete; sampled at the rising edge of Clk.

Behaviour:
- Reset (async, Rst=0): state IDLE; all outputs 0; watchdog 0; any in-flight access is abandoned with no further MemWE.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Start=1 with a supported OpCode latches OpCode, Addr, WriteData, and sets MemAddr={Addr[ADDR_WIDTH-1:2],2'b00}.
  - Misaligned access goes to DONE with AddrErr=1 and no memory access. Misaligned means Addr[1:0]!=0 for LW/SW, or Addr[0]!=0 for LH/SH.
  - Otherwise: LW/LH/LB/SH/SB go to READ; SW goes to WRITE with MemWData=WriteData.
  - Unsupported OpCode with Start=1 is ignored; the block stays in IDLE with Stall=0.
- READ:
  - MemRE=1 is held until MemReady=1.
  - On MemReady, MemRData is captured.
  - Loads: extract lane and go to DONE.
  - SB/SH: merge WriteData low byte/half into the captured word at the addressed lane, load MemWData, and go to WRITE.
- WRITE: MemWE=1 is held until MemReady=1, then go to DONE. MemWE is never asserted in the same cycle as MemRE.
- DONE:
  - Done=1 for exactly one cycle, then IDLE.
  - ReadData, AddrErr and BusErr stay valid until the next Start is accepted.
- Lanes are little-endian: byte k = bits [8k+7:8k], k=Addr[1:0]; half h = bits [16h+15:16h], h=Addr[1].
- LB/LH sign-extend to 32 bits. LW passes the word through. Stores leave ReadData unchanged.
- Stall = (IDLE & Start & supported OpCode) | READ | WRITE; it is combinational and low in DONE.
- Watchdog:
  - Clears on entry to READ or WRITE and increments each cycle MemReady=0.
  - Reaching TIMEOUT goes to DONE with BusErr=1, deasserts MemRE/MemWE, and performs no write for a pending RMW.
- Start outside IDLE is ignored; no queuing.
- Latency, Start to Done with zero-wait memory (MemReady=1 every cycle):
  - LW/SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Misaligned: 1 cycle.

Optional Feature:
UNSIGNED_LOAD_EN:
- Defined: opcodes 100100 LBU and 100101 LHU are supported. They behave as LB/LH with zero-extension, and LHU uses the LH alignment rule.
- Undefined: these opcodes are unsupported and ignored in IDLE (no Stall, no Done).

Test Plan:
- Mem word 0x0=0x8899AABB, MemReady tied 1; LB Addr=0x2 -> Done after 2 cycles, ReadData=0xFFFFFF99, one MemRE cycle, MemWE never high.
- Same word; SB Addr=0x1, WriteData=0x12345677 -> READ then WRITE; MemWData=0x8899_77BB, one MemWE pulse, Done at cycle 3.
- SH Addr=0x2, WriteData=0x0000CAFE over 0x11223344 -> MemWData=0xCAFE3344; LH Addr=0x2 afterward -> 0xFFFFCAFE.
- LW Addr=0x6 -> Done next cycle, AddrErr=1, MemRE/MemWE stay 0; SW Addr=0x4 with MemReady low 3 cycles -> MemWE held 4 cycles, Done on cycle 5.
- MemReady stuck 0 on LW, TIMEOUT=16 -> BusErr=1 with Done after 16 wait cycles, MemRE drops; Rst=0 pulse mid-WRITE of SB -> MemWE falls immediately, state IDLE, all outputs 0.
- LBU (100100) Addr=0x3, word 0x80000000 -> with UNSIGNED_LOAD_EN: ReadData=0x00000080; without it: Stall=0, no Done.
